text_ram_arbiter: RTL and testbench
===================================

# text_ram_arbiter

Single-port text RAM arbiter and sequencer for the editor's 15-row × 20-column character grid. It shares one synchronous RAM port (9-bit address = {row[3:0], col[4:0]}, 8-bit data) among four sources: a full-screen clear sweep, single-cell delete, keyboard write and a generic read port. It also maintains the per-cell "written" bitmap that the VGA path queries to gate glyph display. It sits between the keyboard/mouse editing logic and the text BRAM.

## Interface
Parameters:
- ROWS, 15, number of valid rows (row field 0..ROWS-1)
- COLS, 20, number of valid columns (col field 0..COLS-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- clr_all_req  in  1  one-cycle pulse: start full clear sweep
- del_req  in  1  single-cell clear request (level, held until del_ack)
- del_addr  in  9  cell to clear
- del_ack  out  1  one-cycle grant pulse for del
- wr_req  in  1  write request (level, held until wr_ack)
- wr_addr  in  9  cell to write
- wr_data  in  8  character code
- wr_ack  out  1  one-cycle grant pulse for wr
- rd_req  in  1  read request (level, held until rd_ack)
- rd_addr  in  9  cell to read
- rd_ack  out  1  one-cycle grant pulse for rd
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  read result
- ram_en, ram_we  out  1 each  RAM enable / write enable
- ram_addr  out  9  RAM address
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, 1-cycle latency after ram_en
- vga_block  in  9  cell queried by VGA
- vga_written  out  1  bitmap[vga_block], combinational; 0 for out-of-range cell
- busy  out  1  high while clear sweep active

## Operation
- States: SWEEP, IDLE. Reset enters SWEEP with sweep counter = {0,0}; bitmap all zero.
- SWEEP: one RAM write per cycle, ram_we=1, ram_din=0, addresses row-major over valid cells only ({r,c}, r<ROWS, c<COLS), col wraps 19→0 with row+1; 300 writes total. After writing {14,19} → IDLE. No acks issued in SWEEP; requests stay pending.
- clr_all_req in any state: bitmap cleared in the following cycle, counter reset to {0,0}, state SWEEP (restart if already sweeping).
- IDLE: fixed priority del > wr > rd. A requester whose ack is high this cycle is ineligible this cycle (prevents double grant while req still high).
- Grant del: RAM write 0 at del_addr, bitmap bit cleared. Grant wr: RAM write wr_data at wr_addr, bitmap bit set (even if wr_data=0). Grant rd: RAM read at rd_addr.
- Out-of-range address (row≥ROWS or col≥COLS): request still acked, ram_en=0, bitmap unchanged; for rd, rd_valid pulses with rd_data=0.
- del and wr same cell same cycle: del first, wr on next eligible cycle → cell ends written.

## Timing
- All outputs except vga_written registered. Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_din=0, all acks=0, rd_valid=0, rd_data=0, busy=1.
- Request sampled high in cycle N (IDLE, eligible, winning) → ram_* and matching ack high in cycle N+1 only. Bitmap update visible on vga_written in N+2.
- Read: rd_ack in N+1, rd_valid and rd_data=ram_dout in N+2.
- Requester must drop req (or present a new request) in the cycle after ack; a req still high in the ack cycle is ignored that cycle.
- Sweep after reset release: first write in cycle 1 (addr 0x000), last in cycle 300 (addr 0x1D3); busy=0 from cycle 301; first grant earliest cycle 302.
- Sweep during an outstanding rd (ack issued, rd_valid not yet): rd_valid still delivered in N+2.
- rst assertion mid-operation: outputs to reset values immediately; pending handshakes abandoned.

## Test plan
- Reset release, no requests → exactly 300 writes of 0, addresses 0x000..0x013, 0x020..0x033, …, 0x1C0..0x1D3, busy falls after cycle 300; no write to col≥20 or row 15.
- IDLE, wr_req addr 0x045 data 0x41 → wr_ack and ram_we at N+1 with addr 0x045/din 0x41; vga_written for 0x045 =1 at N+2; rd of 0x045 returns rd_valid/rd_data 0x41 at N+2 after rd_ack.
- del_req, wr_req, rd_req all raised same cycle → acks in order del, wr, rd on successive cycles; no ack repeats while req held through its ack cycle.
- wr_req to 0x1F4 (row 15) → wr_ack, ram_en=0, bitmap unchanged; rd_req to 0x014 (col 20) → rd_valid with rd_data 0x00.
- clr_all_req at sweep cell 150 → sweep restarts at 0x000, total 300 further writes; wr_req held throughout gets wr_ack only after busy=0.
- rst low for one cycle during IDLE write burst → all outputs reset asynchronously, busy=1, sweep restarts from 0x000 on release.

Source files
------------

// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if: bundles the request/ack handshakes, the text RAM port
// and the VGA bitmap query of the text RAM arbiter.
//   clr_all_req            : full-screen clear pulse
//   del_* / wr_* / rd_*    : requester handshakes (req level, ack pulse)
//   rd_valid / rd_data     : read result
//   ram_en/we/addr/din/dout: single synchronous RAM port, address {row,col}
//   vga_block / vga_written: bitmap query from the VGA path
//   busy                   : clear sweep in progress
// Modports: slave = arbiter side, master = requesters / RAM / VGA side.
interface text_ram_arbiter_if;
   logic       clr_all_req;
   logic       del_req;
   logic [8:0] del_addr;
   logic       del_ack;
   logic       wr_req;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       rd_req;
   logic [8:0] rd_addr;
   logic       rd_ack;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       ram_en;
   logic       ram_we;
   logic [8:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic [8:0] vga_block;
   logic       vga_written;
   logic       busy;

   modport slave (
      input  clr_all_req, del_req, del_addr, wr_req, wr_addr, wr_data,
             rd_req, rd_addr, ram_dout, vga_block,
      output del_ack, wr_ack, rd_ack, rd_valid, rd_data,
             ram_en, ram_we, ram_addr, ram_din, vga_written, busy
   );

   modport master (
      output clr_all_req, del_req, del_addr, wr_req, wr_addr, wr_data,
             rd_req, rd_addr, ram_dout, vga_block,
      input  del_ack, wr_ack, rd_ack, rd_valid, rd_data,
             ram_en, ram_we, ram_addr, ram_din, vga_written, busy
   );
endinterface

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares one text RAM port among a full-screen clear sweep,
// single-cell delete, keyboard write and a generic read port, and keeps the
// per-cell "written" bitmap queried by the VGA path.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : text_ram_arbiter_if.slave (handshakes, RAM port, VGA query, busy)
// Priority in IDLE is del > wr > rd; a requester whose ack is high this
// cycle is skipped so a held request is not granted twice.
module text_ram_arbiter #(
   parameter int unsigned ROWS = 15,
   parameter int unsigned COLS = 20
) (
   input  logic                clk,
   input  logic                rst,
   text_ram_arbiter_if.slave   bus
);
   typedef enum logic {SWEEP, IDLE} state_t;

   state_t state, state_nxt;

   logic [3:0]           sw_row;
   logic [4:0]           sw_col;
   logic                 sweep_last;
   logic [ROWS*COLS-1:0] bitmap;

   logic       ram_en_q, ram_we_q, ram_en_d, ram_we_d;
   logic [8:0] ram_addr_q, ram_addr_d;
   logic [7:0] ram_din_q, ram_din_d;
   logic       del_ack_q, wr_ack_q, rd_ack_q;
   logic       del_ack_d, wr_ack_d, rd_ack_d;
   logic       rd_pend_q, rd_pend_d, rd_oor_q, rd_oor_d;
   logic       rd_valid_q, rd_sel_q;
   logic       bm_upd_q, bm_upd_d, bm_val_q, bm_val_d;
   logic [8:0] bm_idx_q, bm_idx_d;
   logic       busy_q, busy_d;
   logic       can_grant, gnt_del, gnt_wr, gnt_rd;

   function automatic logic in_range(input logic [8:0] a);
      return (32'(a[8:5]) < ROWS) && (32'(a[4:0]) < COLS);
   endfunction

   function automatic logic [8:0] cell_idx(input logic [8:0] a);
      return 9'(32'(a[8:5]) * COLS + 32'(a[4:0]));
   endfunction

   assign sweep_last = (32'(sw_row) == ROWS - 1) && (32'(sw_col) == COLS - 1);

   // busy_q also blocks the first IDLE cycle, so the earliest grant after a
   // sweep lands two cycles after its last write.
   assign can_grant = (state == IDLE) && !busy_q && !bus.clr_all_req;
   assign gnt_del   = can_grant && bus.del_req && !del_ack_q;
   assign gnt_wr    = can_grant && bus.wr_req  && !wr_ack_q && !gnt_del;
   assign gnt_rd    = can_grant && bus.rd_req  && !rd_ack_q && !gnt_del && !gnt_wr;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SWEEP;
      else      state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      if (bus.clr_all_req)                    state_nxt = SWEEP;
      else if (state == SWEEP && sweep_last)  state_nxt = IDLE;
   end

   // output logic: next values of the registered outputs
   always_comb begin
      ram_en_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      del_ack_d  = 1'b0;
      wr_ack_d   = 1'b0;
      rd_ack_d   = 1'b0;
      rd_pend_d  = 1'b0;
      rd_oor_d   = 1'b0;
      bm_upd_d   = 1'b0;
      bm_val_d   = 1'b0;
      bm_idx_d   = bm_idx_q;
      busy_d     = (state == SWEEP) || (state_nxt == SWEEP);
      if (state == SWEEP && !bus.clr_all_req) begin
         ram_en_d   = 1'b1;
         ram_we_d   = 1'b1;
         ram_addr_d = {sw_row, sw_col};
         ram_din_d  = '0;
      end else if (gnt_del) begin
         del_ack_d = 1'b1;
         if (in_range(bus.del_addr)) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = bus.del_addr;
            ram_din_d  = '0;
            bm_upd_d   = 1'b1;
            bm_val_d   = 1'b0;
            bm_idx_d   = cell_idx(bus.del_addr);
         end
      end else if (gnt_wr) begin
         wr_ack_d = 1'b1;
         if (in_range(bus.wr_addr)) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = bus.wr_addr;
            ram_din_d  = bus.wr_data;
            bm_upd_d   = 1'b1;
            bm_val_d   = 1'b1;
            bm_idx_d   = cell_idx(bus.wr_addr);
         end
      end else if (gnt_rd) begin
         rd_ack_d  = 1'b1;
         rd_pend_d = 1'b1;
         rd_oor_d  = !in_range(bus.rd_addr);
         if (in_range(bus.rd_addr)) begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.rd_addr;
         end
      end
   end

   // registered outputs, sweep counter and bitmap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         del_ack_q  <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_oor_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_sel_q   <= 1'b0;
         bm_upd_q   <= 1'b0;
         bm_val_q   <= 1'b0;
         bm_idx_q   <= '0;
         busy_q     <= 1'b1;
         sw_row     <= '0;
         sw_col     <= '0;
         bitmap     <= '0;
      end else begin
         ram_en_q   <= ram_en_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         del_ack_q  <= del_ack_d;
         wr_ack_q   <= wr_ack_d;
         rd_ack_q   <= rd_ack_d;
         rd_pend_q  <= rd_pend_d;
         rd_oor_q   <= rd_oor_d;
         rd_valid_q <= rd_pend_q;
         rd_sel_q   <= rd_pend_q && !rd_oor_q;
         bm_upd_q   <= bm_upd_d;
         bm_val_q   <= bm_val_d;
         bm_idx_q   <= bm_idx_d;
         busy_q     <= busy_d;
         if (bus.clr_all_req) begin
            sw_row <= '0;
            sw_col <= '0;
         end else if (state == SWEEP) begin
            if (32'(sw_col) == COLS - 1) begin
               sw_col <= '0;
               sw_row <= sw_row + 4'd1;
            end else begin
               sw_col <= sw_col + 5'd1;
            end
         end
         // Bitmap follows the RAM write by one cycle; a clear overrides it.
         if (bus.clr_all_req) bitmap <= '0;
         else if (bm_upd_q)   bitmap[bm_idx_q] <= bm_val_q;
      end
   end

   assign bus.ram_en   = ram_en_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.del_ack  = del_ack_q;
   assign bus.wr_ack   = wr_ack_q;
   assign bus.rd_ack   = rd_ack_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = busy_q;
   // RAM data arrives in the rd_valid cycle itself, so rd_data is a mux under
   // registered control rather than a second register stage.
   assign bus.rd_data  = rd_sel_q ? bus.ram_dout : '0;
   assign bus.vga_written = in_range(bus.vga_block) ? bitmap[cell_idx(bus.vga_block)] : 1'b0;
endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb_text_ram_arbiter: directed self-checking bench for text_ram_arbiter with
// a behavioural synchronous RAM and a sweep-write monitor.
module tb_text_ram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   text_ram_arbiter_if bus ();

   text_ram_arbiter #(.ROWS(15), .COLS(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // synchronous RAM, 1-cycle read latency
   logic [7:0] mem [0:511];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
         else            bus.ram_dout <= mem[bus.ram_addr];
      end
   end

   // sweep monitor: counts writes and flags any deviation from row-major order
   logic       mon_rst = 1'b1;
   int         mon_cnt = 0;
   int         mon_bad = 0;
   logic [3:0] mon_r = '0;
   logic [4:0] mon_c = '0;
   always @(posedge clk) begin
      if (mon_rst) begin
         mon_cnt <= 0; mon_bad <= 0; mon_r <= '0; mon_c <= '0;
      end else if (bus.ram_en && bus.ram_we) begin
         if (bus.ram_addr !== {mon_r, mon_c} || bus.ram_din !== 8'h00) mon_bad <= mon_bad + 1;
         mon_cnt <= mon_cnt + 1;
         if (mon_c == 5'd19) begin mon_c <= '0; mon_r <= mon_r + 4'd1; end
         else mon_c <= mon_c + 5'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_ack_seen;
      for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
      bus.ram_dout = 8'h00;
      bus.clr_all_req = 0; bus.del_req = 0; bus.wr_req = 0; bus.rd_req = 0;
      bus.del_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
      bus.vga_block = 9'h045;
      #1 rst = 1'b0;
      repeat (3) step();
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_din", bus.ram_din, 0);
      check("rst_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_busy", bus.busy, 1);

      // ---- sweep after reset release ----
      rst = 1'b1; mon_rst = 1'b0;
      step();
      check("sw1_en_we", {bus.ram_en, bus.ram_we}, 2'b11);
      check("sw1_addr", bus.ram_addr, 9'h000);
      repeat (299) step();
      check("sw300_addr", bus.ram_addr, 9'h1D3);
      check("sw300_busy", bus.busy, 1);
      step();
      check("sw301_busy", bus.busy, 0);
      check("sw301_en", bus.ram_en, 0);
      check("sw_count", mon_cnt, 300);
      check("sw_order", mon_bad, 0);

      // ---- write 0x045 = 0x41, then read it back ----
      bus.wr_req = 1; bus.wr_addr = 9'h045; bus.wr_data = 8'h41; bus.vga_block = 9'h045;
      step();
      check("wr_ack", bus.wr_ack, 1);
      check("wr_ram", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din}, {2'b11, 9'h045, 8'h41});
      check("wr_vga_n1", bus.vga_written, 0);
      bus.wr_req = 0;
      step();
      check("wr_ack_drop", bus.wr_ack, 0);
      check("wr_vga_n2", bus.vga_written, 1);
      bus.rd_req = 1; bus.rd_addr = 9'h045;
      step();
      check("rd_ack", bus.rd_ack, 1);
      check("rd_ram", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b10, 9'h045});
      check("rd_valid_n1", bus.rd_valid, 0);
      bus.rd_req = 0;
      step();
      check("rd_valid_n2", bus.rd_valid, 1);
      check("rd_data_n2", bus.rd_data, 8'h41);
      check("rd_ack_drop", bus.rd_ack, 0);
      step();
      check("rd_valid_n3", bus.rd_valid, 0);

      // ---- simultaneous del/wr/rd on 0x045, each held through its ack ----
      bus.del_req = 1; bus.del_addr = 9'h045;
      bus.wr_req = 1;  bus.wr_addr = 9'h045; bus.wr_data = 8'h42;
      bus.rd_req = 1;  bus.rd_addr = 9'h045;
      step();
      check("pri1_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 3'b100);
      check("pri1_ram", {bus.ram_we, bus.ram_addr, bus.ram_din}, {1'b1, 9'h045, 8'h00});
      step();
      check("pri2_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 3'b010);
      check("pri2_ram_din", bus.ram_din, 8'h42);
      check("pri2_vga_del", bus.vga_written, 0);
      bus.del_req = 0;
      step();
      check("pri3_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 3'b001);
      bus.wr_req = 0;
      step();
      check("pri4_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 3'b000);
      check("pri4_rd", {bus.rd_valid, bus.rd_data}, {1'b1, 8'h42});
      check("pri4_vga", bus.vga_written, 1);
      bus.rd_req = 0;
      step();
      check("pri5_acks", {bus.del_ack, bus.wr_ack, bus.rd_ack}, 3'b000);

      // ---- out-of-range write and read ----
      bus.wr_req = 1; bus.wr_addr = 9'h1F4; bus.wr_data = 8'h55; bus.vga_block = 9'h1F4;
      step();
      check("oor_wr_ack", bus.wr_ack, 1);
      check("oor_wr_en", bus.ram_en, 0);
      bus.wr_req = 0;
      step();
      check("oor_wr_vga", bus.vga_written, 0);
      bus.vga_block = 9'h045;
      #1;
      check("oor_bitmap_kept", bus.vga_written, 1);
      bus.rd_req = 1; bus.rd_addr = 9'h014;
      step();
      check("oor_rd_ack", bus.rd_ack, 1);
      check("oor_rd_en", bus.ram_en, 0);
      bus.rd_req = 0;
      step();
      check("oor_rd", {bus.rd_valid, bus.rd_data}, {1'b1, 8'h00});

      // ---- clear, restart mid-sweep, write held through the sweep ----
      bus.clr_all_req = 1; mon_rst = 1;
      step();
      bus.clr_all_req = 0; mon_rst = 0;
      check("clr_busy", bus.busy, 1);
      check("clr_en", bus.ram_en, 0);
      check("clr_bitmap", bus.vga_written, 0);
      bus.wr_req = 1; bus.wr_addr = 9'h046; bus.wr_data = 8'h33;
      wr_ack_seen = 0;
      repeat (151) begin
         step();
         if (bus.wr_ack) wr_ack_seen++;
      end
      check("clr_cell150", bus.ram_addr, 9'h0EA);
      bus.clr_all_req = 1; mon_rst = 1;
      step();
      bus.clr_all_req = 0; mon_rst = 0;
      check("reclr_en", bus.ram_en, 0);
      check("reclr_busy", bus.busy, 1);
      step();
      check("reclr_first", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b11, 9'h000});
      repeat (299) begin
         if (bus.wr_ack) wr_ack_seen++;
         step();
      end
      check("reclr_last", bus.ram_addr, 9'h1D3);
      check("reclr_last_busy", bus.busy, 1);
      step();
      if (bus.wr_ack) wr_ack_seen++;
      check("reclr_busy_fall", bus.busy, 0);
      check("reclr_count", mon_cnt, 300);
      check("reclr_order", mon_bad, 0);
      check("no_ack_in_sweep", wr_ack_seen, 0);
      step();
      check("held_wr_ack", bus.wr_ack, 1);
      check("held_wr_ram", {bus.ram_addr, bus.ram_din}, {9'h046, 8'h33});

      // ---- reset during a write burst (held wr_req) ----
      bus.wr_addr = 9'h050; bus.wr_data = 8'h77;
      step();
      step();
      check("burst_ack", bus.wr_ack, 1);
      rst = 1'b0; mon_rst = 1;
      #1;
      check("arst_en_we", {bus.ram_en, bus.ram_we}, 2'b00);
      check("arst_ack", bus.wr_ack, 0);
      check("arst_addr_din", {bus.ram_addr, bus.ram_din}, 0);
      check("arst_busy", bus.busy, 1);
      bus.wr_req = 0;
      step();
      rst = 1'b1; mon_rst = 0;
      step();
      check("rst2_first", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b11, 9'h000});
      check("rst2_bitmap", bus.vga_written, 0);
      repeat (300) step();
      check("rst2_count", mon_cnt, 300);
      check("rst2_order", mon_bad, 0);
      check("rst2_busy", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
